// File: rtl/timer_hex_display.sv
// Multi-channel countdown timer with a fixed-priority seven-segment readout.
// Each channel runs IDLE -> RUN -> FLASH on a shared tick; one channel is shown at a time.
module timer_hex_display #(
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned CNT_W       = 7,
    parameter int unsigned FLASH_TICKS = 4,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      abort,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS*CNT_W-1:0] load_val,
    input  logic [CHANNELS*7-1:0]     mode_glyph,
    output logic [6:0]                hex_mode,
    output logic [DIGITS*7-1:0]       hex_count,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       done
);

    localparam int unsigned      MaxVal    = 10 ** DIGITS - 1;
    localparam logic [CNT_W-1:0] MaxCnt    = CNT_W'(MaxVal);
    localparam logic [3:0]       FlashInit = 4'(FLASH_TICKS);
    localparam logic [6:0]       Blank7    = {7{ACTIVE_LOW}};

    typedef enum logic [1:0] {StIdle, StRun, StFlash} state_e;

    state_e             state_q [CHANNELS];
    state_e             state_d [CHANNELS];
    logic [CNT_W-1:0]   count_q [CHANNELS];
    logic [CNT_W-1:0]   count_d [CHANNELS];
    logic [3:0]         flash_q [CHANNELS];
    logic [3:0]         flash_d [CHANNELS];
    logic [CHANNELS-1:0] phase_q, phase_d;
    logic [CHANNELS-1:0] busy_q, busy_d;
    logic [CHANNELS-1:0] done_q, done_d;

    logic [6:0]          hex_mode_q, hex_mode_d;
    logic [DIGITS*7-1:0] hex_count_q, hex_count_d;

    function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] v);
        return (v > MaxCnt) ? MaxCnt : v;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        unique case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i] <= StIdle;
                count_q[i] <= '0;
                flash_q[i] <= '0;
            end
            phase_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                state_q[i] <= state_d[i];
                count_q[i] <= count_d[i];
                flash_q[i] <= flash_d[i];
            end
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; abort dominates start and tick
    always_comb begin
        phase_d = phase_q;
        busy_d  = '0;
        done_d  = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            flash_d[i] = flash_q[i];
            if (abort) begin
                state_d[i] = StIdle;
                count_d[i] = '0;
                flash_d[i] = '0;
                phase_d[i] = 1'b0;
            end else begin
                unique case (state_q[i])
                    StIdle: begin
                        if (start[i]) begin
                            state_d[i] = StRun;
                            count_d[i] = clamp_load(load_val[i*CNT_W +: CNT_W]);
                        end
                    end
                    StRun: begin
                        if (tick) begin
                            if (count_q[i] == '0) begin
                                state_d[i] = StFlash;
                                flash_d[i] = FlashInit;
                                phase_d[i] = 1'b1;
                                done_d[i]  = 1'b1;
                            end else begin
                                count_d[i] = count_q[i] - 1'b1;
                            end
                        end
                    end
                    StFlash: begin
                        if (start[i]) begin
                            state_d[i] = StRun;
                            count_d[i] = clamp_load(load_val[i*CNT_W +: CNT_W]);
                            flash_d[i] = '0;
                            phase_d[i] = 1'b0;
                        end else if (tick) begin
                            if (flash_q[i] == 4'd1) begin
                                state_d[i] = StIdle;
                                flash_d[i] = '0;
                                phase_d[i] = 1'b0;
                            end else begin
                                flash_d[i] = flash_q[i] - 4'd1;
                                phase_d[i] = ~phase_q[i];
                            end
                        end
                    end
                    default: state_d[i] = StIdle;
                endcase
            end
            busy_d[i] = (state_d[i] != StIdle);
        end
    end

    // Display selection and decimal decode from the current state
    logic                run_hit, flash_hit, flash_on;
    logic [6:0]          run_glyph, flash_glyph, mode_raw;
    logic [CNT_W-1:0]    run_cnt;
    logic [DIGITS*7-1:0] count_raw;
    int unsigned         val, pow;

    always_comb begin
        run_hit     = 1'b0;
        flash_hit   = 1'b0;
        flash_on    = 1'b0;
        run_glyph   = '0;
        flash_glyph = '0;
        run_cnt     = '0;
        mode_raw    = '0;
        count_raw   = '0;
        val         = 0;
        pow         = 1;
        // Scan downwards so the lowest index overwrites last
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (state_q[i] == StRun) begin
                run_hit   = 1'b1;
                run_glyph = mode_glyph[i*7 +: 7];
                run_cnt   = count_q[i];
            end
            if (state_q[i] == StFlash) begin
                flash_hit   = 1'b1;
                flash_glyph = mode_glyph[i*7 +: 7];
                flash_on    = phase_q[i];
            end
        end
        if (run_hit) begin
            mode_raw = run_glyph;
            val      = 32'(run_cnt);
            for (int d = 0; d < int'(DIGITS); d++) begin
                if (d == 0 || 32'(run_cnt) >= pow) begin
                    count_raw[d*7 +: 7] = seg7(4'(val % 10));
                end
                val = val / 10;
                pow = pow * 10;
            end
        end else if (flash_hit && flash_on) begin
            mode_raw       = flash_glyph;
            count_raw[6:0] = seg7(4'd0);
        end
        hex_mode_d  = mode_raw ^ Blank7;
        hex_count_d = count_raw ^ {DIGITS{Blank7}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_mode_q  <= Blank7;
            hex_count_q <= {DIGITS{Blank7}};
        end else begin
            hex_mode_q  <= hex_mode_d;
            hex_count_q <= hex_count_d;
        end
    end

    assign hex_mode  = hex_mode_q;
    assign hex_count = hex_count_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_timer_hex_display.sv
// Randomised scoreboard bench for timer_hex_display against a per-channel countdown model.
module tb_timer_hex_display;

    localparam int CH    = 3;
    localparam int DG    = 2;
    localparam int CW    = 7;
    localparam int FT    = 4;
    localparam int MAXV  = 99;
    localparam int IDLE  = 0;
    localparam int RUN   = 1;
    localparam int FLASH = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             tick = 1'b0;
    logic             abort = 1'b0;
    logic [CH-1:0]    start = '0;
    logic [CH*CW-1:0] load_val = '0;
    logic [CH*7-1:0]  mode_glyph = '0;
    logic [6:0]       hex_mode;
    logic [DG*7-1:0]  hex_count;
    logic [CH-1:0]    busy;
    logic [CH-1:0]    done;

    always #5 clk = ~clk;

    timer_hex_display #(
        .CHANNELS   (CH),
        .DIGITS     (DG),
        .CNT_W      (CW),
        .FLASH_TICKS(FT),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .abort     (abort),
        .start     (start),
        .load_val  (load_val),
        .mode_glyph(mode_glyph),
        .hex_mode  (hex_mode),
        .hex_count (hex_count),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [CH-1:0]   busy;
        logic [CH-1:0]   done;
        logic [6:0]      mode;
        logic [DG*7-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    int   m_state[CH];
    int   m_cnt[CH];
    int   m_fl[CH];
    bit   m_ph[CH];
    logic [CH*7-1:0] glyph_v = {7'b1110001, 7'b0111000, 7'b1000000};
    logic [6:0] seg_tbl[10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // What the display should show for the model's current state (active-low)
    task automatic model_display(output logic [6:0] m, output logic [DG*7-1:0] c);
        int sel;
        int p;
        sel = -1;
        p = 1;
        for (int i = CH - 1; i >= 0; i--) if (m_state[i] == FLASH) sel = i;
        for (int i = CH - 1; i >= 0; i--) if (m_state[i] == RUN) sel = i;
        m = '0;
        c = '0;
        if (sel >= 0) begin
            if (m_state[sel] == RUN) begin
                m = mode_glyph[sel*7 +: 7];
                for (int d = 0; d < DG; d++) begin
                    if (d == 0 || m_cnt[sel] >= p) c[d*7 +: 7] = seg_tbl[(m_cnt[sel] / p) % 10];
                    p = p * 10;
                end
            end else if (m_ph[sel]) begin
                m = mode_glyph[sel*7 +: 7];
                c[6:0] = seg_tbl[0];
            end
        end
        m = ~m;
        c = ~c;
    endtask

    task automatic step(input bit tk, input bit ab, input logic [CH-1:0] st,
                        input logic [CH*CW-1:0] lv);
        exp_t e;
        logic [6:0] dm;
        logic [DG*7-1:0] dc;
        @(negedge clk);
        tick = tk;
        abort = ab;
        start = st;
        load_val = lv;
        mode_glyph = glyph_v;
        model_display(dm, dc);
        e.done = '0;
        e.busy = '0;
        for (int i = 0; i < CH; i++) begin
            int v;
            v = int'(lv[i*CW +: CW]);
            if (v > MAXV) v = MAXV;
            if (ab) begin
                m_state[i] = IDLE;
                m_cnt[i] = 0;
            end else if (m_state[i] == IDLE) begin
                if (st[i]) begin
                    m_state[i] = RUN;
                    m_cnt[i] = v;
                end
            end else if (m_state[i] == RUN) begin
                if (tk) begin
                    if (m_cnt[i] == 0) begin
                        e.done[i] = 1'b1;
                        m_state[i] = FLASH;
                        m_fl[i] = FT;
                        m_ph[i] = 1'b1;
                    end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end
                end
            end else begin
                if (st[i]) begin
                    m_state[i] = RUN;
                    m_cnt[i] = v;
                end else if (tk) begin
                    m_fl[i] = m_fl[i] - 1;
                    m_ph[i] = !m_ph[i];
                    if (m_fl[i] == 0) m_state[i] = IDLE;
                end
            end
            e.busy[i] = (m_state[i] != IDLE);
        end
        e.mode = dm;
        e.cnt = dc;
        sb_q.push_back(e);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(1'b1, 1'b0, '0, '0);
            step(1'b0, 1'b0, '0, '0);
            step(1'b0, 1'b0, '0, '0);
        end
    endtask

    function automatic logic [CH*CW-1:0] lv_one(input int ch, input int val);
        logic [CH*CW-1:0] r;
        r = '0;
        r[ch*CW +: CW] = CW'(val);
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_hex_mode", 32'(hex_mode), 32'h7F);
        check("reset_hex_count", 32'(hex_count), 32'h3FFF);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        for (int i = 0; i < CH; i++) begin
            m_state[i] = IDLE;
            m_cnt[i] = 0;
            m_fl[i] = 0;
            m_ph[i] = 1'b0;
        end
        @(negedge clk);
        tick = 1'b0;
        abort = 1'b0;
        start = '0;
        rst_n = 1'b1;
    endtask

    // Monitor: compare whatever the driver predicted for this edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("busy", 32'(busy), 32'(e.busy));
                check("done", 32'(done), 32'(e.done));
                check("hex_mode", 32'(hex_mode), 32'(e.mode));
                check("hex_count", 32'(hex_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        // ch0 from 5: six RUN ticks, then four flash ticks
        step(1'b0, 1'b0, 3'b001, lv_one(0, 5));
        ticks(11);
        // Two-digit value and clamping
        step(1'b0, 1'b0, 3'b001, lv_one(0, 99));
        ticks(2);
        step(1'b0, 1'b1, '0, '0);
        step(1'b0, 1'b0, 3'b001, lv_one(0, 120));
        ticks(1);
        step(1'b0, 1'b1, '0, '0);
        // Priority: ch2 running, ch1 preempts then expires
        step(1'b0, 1'b0, 3'b100, lv_one(2, 7));
        ticks(2);
        step(1'b0, 1'b0, 3'b010, lv_one(1, 3));
        ticks(16);
        // Start ignored in RUN, honoured in FLASH
        step(1'b0, 1'b0, 3'b001, lv_one(0, 6));
        ticks(2);
        step(1'b0, 1'b0, 3'b001, lv_one(0, 9));
        ticks(6);
        step(1'b0, 1'b0, 3'b001, lv_one(0, 2));
        ticks(8);
        // Abort with ch0 counting and ch1 flashing
        step(1'b0, 1'b0, 3'b011, lv_one(0, 4));
        ticks(2);
        step(1'b1, 1'b1, 3'b011, lv_one(0, 4) | lv_one(1, 4));
        step(1'b0, 1'b0, '0, '0);
        // Simultaneous start, then reset mid-count
        step(1'b0, 1'b0, 3'b111, lv_one(0, 8) | lv_one(1, 12) | lv_one(2, 30));
        ticks(2);
        do_reset();
        ticks(3);
        // Randomised traffic
        for (int k = 0; k < 4000; k++) begin
            logic [CH-1:0] st;
            logic [CH*CW-1:0] lv;
            for (int i = 0; i < CH; i++) begin
                st[i] = ($urandom_range(0, 9) == 0);
                lv[i*CW +: CW] = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 127))
                                                               : CW'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 99) == 0) glyph_v = (CH*7)'($urandom);
            if ($urandom_range(0, 1499) == 0) do_reset();
            step($urandom_range(0, 2) == 0, $urandom_range(0, 149) == 0, st, lv);
        end
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_hex_display.md
# timer_hex_display

Parametrised multi-channel countdown timer with integrated seven-segment driver for the chamber controller. It holds CHANNELS independent down-counters, each started by its own pulse and decremented on a shared tick enable. It selects one channel by fixed priority and drives one mode-glyph digit plus DIGITS decimal count digits, with leading-zero blanking and an expiry flash. It sits between the chamber FSM (start/abort/tick) and the HEX display pins.

## Interface
- CHANNELS, 3, number of independent timers (1..8)
- DIGITS, 2, decimal count digits displayed (1..3)
- CNT_W, 7, counter width; must satisfy 2^CNT_W > 10^DIGITS - 1
- FLASH_TICKS, 4, ticks spent in expiry flash (1..15)
- ACTIVE_LOW, 1, 1 = segment outputs inverted (lit = 0)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle count enable (e.g. 1 Hz strobe)
- abort  in  1  forces every channel to IDLE
- start  in  CHANNELS  per-channel start pulse
- load_val  in  CHANNELS*CNT_W  per-channel start value, channel i at [i*CNT_W +: CNT_W]
- mode_glyph  in  CHANNELS*7  per-channel mode segment pattern, active-high, bit 6..0 = g..a
- hex_mode  out  7  mode digit segments
- hex_count  out  DIGITS*7  count digits, digit 0 (units) at [6:0]
- busy  out  CHANNELS  channel in RUN or FLASH
- done  out  CHANNELS  one-cycle pulse on expiry

## Operation
- Per-channel states: IDLE, RUN, FLASH; per-channel count (CNT_W) and flash counter (4 bits).
- IDLE: start → load count = min(load_val, 10^DIGITS − 1), go RUN. tick in the same cycle is ignored.
- RUN on tick: count > 0 → count − 1; count == 0 → done pulse, flash counter = FLASH_TICKS, phase = on, go FLASH.
- RUN: start is ignored. There is no restart while running.
- FLASH on tick: toggle phase, decrement flash counter. When the counter reaches 0 → IDLE.
- FLASH: start reloads and goes RUN.
- abort: all channels → IDLE and counts cleared, same edge. Overrides start and tick. No done pulse.
- Display selection:
  - Lowest-index channel in RUN.
  - Otherwise lowest-index channel in FLASH.
  - Otherwise none.
- Selected RUN channel:
  - hex_mode = its glyph.
  - hex_count = decimal count.
  - Digits above the most significant nonzero digit are blanked; digit 0 is always shown.
- Selected FLASH channel:
  - phase on → glyph and "0".
  - phase off → all digits blank.
- No selection: all digits blank.
- Digit patterns (g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. Blank = 0000000.
- ACTIVE_LOW=1 inverts every output segment bit, including blanks (blank = 1111111).
- Binary-to-BCD conversion is combinational on the selected count. Only the final segment register is clocked.

## Timing
- Reset (async assert, sync release):
  - All channels IDLE, counts 0.
  - busy = 0, done = 0.
  - hex_mode and hex_count blank (all 1s when ACTIVE_LOW=1).
- busy and done are registered. done is high for exactly the cycle after the expiring tick edge.
- Segment outputs lag channel state by one clock. State changing at edge N is displayed after edge N+1.
- start in cycle t:
  - busy high after edge t+1.
  - Loaded value displayed after edge t+2.
- Count 0 is displayed for one full tick period before expiry.
- Total RUN duration = load_val + 1 ticks.
- Simultaneous start on several IDLE channels: all load. The display shows the lowest index.
- Reset mid-operation: immediate return to reset values. There is no resume.

## Test plan
- Reset, then start[0] with load_val=5, glyph=1000000, ACTIVE_LOW=1. Apply 6 ticks:
  - Display shows "5".."0" with hex_count[13:7] = 1111111 (blanked tens).
  - done[0] pulses once after the 6th tick.
  - Then 4 ticks alternate "0"/blank, then busy[0] = 0.
- load_val=99 → tens = ~1101111, units = ~1101111. load_val=120 → clamped to 99.
- Ch2 running at 7, start ch1 load 3 → display switches to ch1 glyph and "3". After ch1 expires, the display returns to ch2's current count.
- start[0] pulsed during RUN with count=4 → count unchanged. start during FLASH → reload and RUN.
- abort while ch0 at count 2 and ch1 flashing → both busy low next cycle, no done pulse, display blank.
- rst_n low mid-count → outputs blank asynchronously. After release, tick alone leaves everything idle.
